ofmap_stream_collector: RTL

// - Receives the systolic-array result stream of one CNN layer and reorders it into ofmap order.
// - Each input beat is one output pixel p (p = y*OH + x) carrying all K filter results.
// - Emits one ofmap element per beat in k-major, then y, then x order to the next layer.
// - Optional ReLU is applied on output. Single frame buffer: FILL and DRAIN phases alternate.

---
 rtl/ofmap_stream_collector.sv | 111 +++++++++++
 1 files changed

// File: rtl/ofmap_stream_collector.sv
// Collects one layer's per-pixel, all-filter result beats into a frame buffer and
// drains them in k-major, row, column order, with optional ReLU on the way out.
module ofmap_stream_collector #(
    parameter int BW   = 16,
    parameter int K    = 4,
    parameter int OH   = 4,
    parameter int RELU = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [K*BW-1:0]                        in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [BW-1:0]                          out_data,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0]   out_k,
    output logic [((OH > 1) ? $clog2(OH) : 1)-1:0] out_y,
    output logic [((OH > 1) ? $clog2(OH) : 1)-1:0] out_x,
    output logic                                   out_last,
    output logic                                   frame_done,
    output logic                                   err
);
    localparam int NPIX = OH * OH;
    localparam int NEL  = K * NPIX;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int OW   = (NEL > 1) ? $clog2(NEL) : 1;
    localparam int KW   = (K > 1) ? $clog2(K) : 1;
    localparam int YW   = (OH > 1) ? $clog2(OH) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);
    localparam logic [OW-1:0] O_LAST = OW'(NEL - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state;
    logic [PW-1:0] pcnt;
    logic [OW-1:0] ocnt;
    logic          in_accept;
    logic          out_fire;
    logic [BW-1:0] mem [NEL];

    function automatic logic [BW-1:0] relu_fn(input logic [BW-1:0] v);
        if (RELU != 0 && v[BW-1])
            return '0;
        return v;
    endfunction

    assign in_ready   = (state == FILL);
    assign out_valid  = (state == DRAIN);
    assign in_accept  = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign out_last   = out_valid && (ocnt == O_LAST);
    assign frame_done = out_fire && (ocnt == O_LAST);
    assign out_data   = relu_fn(mem[ocnt]);

    always_comb begin
        int oi;
        int pix;
        oi    = int'(ocnt);
        pix   = oi % NPIX;
        out_k = KW'(oi / NPIX);
        out_y = YW'(pix / OH);
        out_x = YW'(pix % OH);
    end

    // Frame boundaries are set by pcnt alone; in_last only feeds the sticky err flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            pcnt  <= '0;
            ocnt  <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_accept) begin
                        if (in_last != (pcnt == P_LAST))
                            err <= 1'b1;
                        if (pcnt == P_LAST) begin
                            pcnt  <= '0;
                            ocnt  <= '0;
                            state <= DRAIN;
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (ocnt == O_LAST) begin
                            ocnt  <= '0;
                            state <= FILL;
                        end else begin
                            ocnt <= ocnt + 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Buffer is data only: never reset, stable for the whole drain phase.
    always_ff @(posedge clk) begin
        if (in_accept) begin
            for (int k = 0; k < K; k++)
                mem[k * NPIX + int'(pcnt)] <= in_data[k*BW +: BW];
        end
    end
endmodule
